// File: rtl/vga_sync_monitor.sv
// Sink-side VGA timing checker: recovers h/v position from the syncs, locks
// after clean frames and reports the per-frame bounding box of lit pixels.
module vga_sync_monitor #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_ALIGN     = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic [1:0] vga_r,
  input  logic [1:0] vga_g,
  input  logic [1:0] vga_b,
  input  logic       clr_err,
  output logic       locked,
  output logic       frame_done,
  output logic       bbox_valid,
  output logic [9:0] bbox_x0,
  output logic [9:0] bbox_y0,
  output logic [9:0] bbox_x1,
  output logic [9:0] bbox_y1,
  output logic [3:0] err
);

  // state   | meaning
  // SEARCH  | waiting for a vsync fall to start measuring
  // MEASURE | counting consecutive clean frames
  // LOCKED  | timing trusted, bounding box published each frame
  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  localparam logic [10:0] LP_H_TOTAL = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0]  LP_H_SYNC  = 10'(H_SYNC);
  localparam logic [9:0]  LP_V_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  LP_V_SYNC  = 10'(V_SYNC);
  localparam logic [9:0]  LP_HS      = 10'(H_SYNC + H_BP + H_ALIGN);
  localparam logic [9:0]  LP_HE      = 10'(H_SYNC + H_BP + H_ALIGN + H_VISIBLE);
  localparam logic [9:0]  LP_VS      = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  LP_VE      = 10'(V_SYNC + V_BP + V_VISIBLE);
  localparam logic [2:0]  LP_LOCK    = 3'(LOCK_FRAMES);
  localparam logic [9:0]  LP_MAX     = 10'h3FF;

  logic       r_hs1, r_vs1, r_hs2, r_vs2;
  logic [5:0] r_rgb1, r_rgb2;
  logic       r_hs_fall, r_hs_rise, r_vs_fall, r_vs_rise, r_hs_low, r_vs_low;
  logic [9:0] r_hcnt, r_lcnt, r_hs_wid, r_vs_wid;
  logic       r_have_line, r_have_vs;
  logic       r_any;
  logic [9:0] r_min_x, r_min_y, r_max_x, r_max_y;
  state_t     r_state;
  logic [2:0] r_good;
  logic       r_ferr;
  logic       r_locked, r_frame_done, r_bbox_valid;
  logic [9:0] r_bbox_x0, r_bbox_y0, r_bbox_x1, r_bbox_y1;
  logic [3:0] r_err;

  logic [9:0] w_hcnt, w_lcnt, w_lcnt_inc, w_x, w_y;
  logic [3:0] w_ev;
  logic       w_err_any, w_active, w_lit;

  // Two register stages: input capture, then edge detect with data kept aligned.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_hs2     <= 1'b1;
      r_vs2     <= 1'b1;
      r_rgb1    <= '0;
      r_rgb2    <= '0;
      r_hs_fall <= 1'b0;
      r_hs_rise <= 1'b0;
      r_vs_fall <= 1'b0;
      r_vs_rise <= 1'b0;
      r_hs_low  <= 1'b0;
      r_vs_low  <= 1'b0;
    end else begin
      r_hs1     <= vga_hsync;
      r_vs1     <= vga_vsync;
      r_rgb1    <= {vga_r, vga_g, vga_b};
      r_hs2     <= r_hs1;
      r_vs2     <= r_vs1;
      r_rgb2    <= r_rgb1;
      r_hs_fall <= r_hs2 & ~r_hs1;
      r_hs_rise <= ~r_hs2 & r_hs1;
      r_vs_fall <= r_vs2 & ~r_vs1;
      r_vs_rise <= ~r_vs2 & r_vs1;
      r_hs_low  <= ~r_hs1;
      r_vs_low  <= ~r_vs1;
    end
  end

  assign w_hcnt     = r_hs_fall ? '0 : ((r_hcnt == LP_MAX) ? r_hcnt : r_hcnt + 10'd1);
  assign w_lcnt_inc = (r_lcnt == LP_MAX) ? r_lcnt : r_lcnt + 10'd1;
  assign w_lcnt     = r_vs_fall ? '0 : (r_hs_fall ? w_lcnt_inc : r_lcnt);

  assign w_ev[0] = r_hs_fall & r_have_line & (({1'b0, r_hcnt} + 11'd1) != LP_H_TOTAL);
  assign w_ev[1] = r_hs_rise & r_have_line & (r_hs_wid != LP_H_SYNC);
  assign w_ev[2] = r_vs_fall & (r_state != S_SEARCH) & (r_lcnt != LP_V_LAST);
  assign w_ev[3] = r_vs_rise & r_have_vs & (r_vs_wid != LP_V_SYNC);
  assign w_err_any = |w_ev;

  assign w_active = (w_hcnt >= LP_HS) && (w_hcnt < LP_HE) && (w_lcnt >= LP_VS) && (w_lcnt < LP_VE);
  assign w_lit    = w_active && (r_rgb2 != 6'd0);
  assign w_x      = w_hcnt - LP_HS;
  assign w_y      = w_lcnt - LP_VS;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_hs_wid    <= '0;
      r_vs_wid    <= '0;
      r_have_line <= 1'b0;
      r_have_vs   <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt;
      r_lcnt <= w_lcnt;
      if (r_hs_fall) begin
        r_have_line <= 1'b1;
        r_hs_wid    <= 10'd1;
      end else if (r_hs_low && r_hs_wid != LP_MAX) begin
        r_hs_wid <= r_hs_wid + 10'd1;
      end
      // Vsync width is measured in lines: hs_falls seen while vsync is low.
      if (r_vs_fall) begin
        r_have_vs <= 1'b1;
        r_vs_wid  <= {9'd0, r_hs_fall};
      end else if (r_vs_low && r_hs_fall && r_vs_wid != LP_MAX) begin
        r_vs_wid <= r_vs_wid + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_any   <= 1'b0;
      r_min_x <= '0;
      r_min_y <= '0;
      r_max_x <= '0;
      r_max_y <= '0;
    end else if (r_vs_fall) begin
      r_any   <= w_lit && (r_state == S_LOCKED) && !w_err_any;
      r_min_x <= w_x;
      r_min_y <= w_y;
      r_max_x <= w_x;
      r_max_y <= w_y;
    end else if (r_state == S_LOCKED && w_lit) begin
      r_any   <= 1'b1;
      r_min_x <= (!r_any || w_x < r_min_x) ? w_x : r_min_x;
      r_min_y <= (!r_any || w_y < r_min_y) ? w_y : r_min_y;
      r_max_x <= (!r_any || w_x > r_max_x) ? w_x : r_max_x;
      r_max_y <= (!r_any || w_y > r_max_y) ? w_y : r_max_y;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_SEARCH;
      r_good       <= '0;
      r_ferr       <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
      r_bbox_valid <= 1'b0;
      r_bbox_x0    <= '0;
      r_bbox_y0    <= '0;
      r_bbox_x1    <= '0;
      r_bbox_y1    <= '0;
      r_err        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_err        <= clr_err ? w_ev : (r_err | w_ev);
      unique case (r_state)
        S_SEARCH: begin
          if (r_vs_fall && !w_err_any) begin
            r_state <= S_MEASURE;
            r_good  <= '0;
            r_ferr  <= 1'b0;
          end
        end
        S_MEASURE: begin
          if (r_vs_fall) begin
            if (w_err_any || r_ferr) begin
              r_state <= S_SEARCH;
            end else if (r_good + 3'd1 == LP_LOCK) begin
              r_state  <= S_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_good <= r_good + 3'd1;
            end
          end else if (w_err_any) begin
            r_ferr <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_err_any) begin
            r_state  <= S_SEARCH;
            r_locked <= 1'b0;
          end else if (r_vs_fall) begin
            r_frame_done <= 1'b1;
            r_bbox_valid <= r_any;
            r_bbox_x0    <= r_any ? r_min_x : '0;
            r_bbox_y0    <= r_any ? r_min_y : '0;
            r_bbox_x1    <= r_any ? r_max_x : '0;
            r_bbox_y1    <= r_any ? r_max_y : '0;
          end
        end
        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign frame_done = r_frame_done;
  assign bbox_valid = r_bbox_valid;
  assign bbox_x0    = r_bbox_x0;
  assign bbox_y0    = r_bbox_y0;
  assign bbox_x1    = r_bbox_x1;
  assign bbox_y1    = r_bbox_y1;
  assign err        = r_err;

endmodule
